// File: rtl/load_store_unit.sv
// Byte/half/word load-store to word memory; latency accept->resp 2 (load, word store), 3 (sub-word store), 1 (error).
// Backpressure: one request in flight, REQ_READY only in IDLE, response held until RESP_READY.
module load_store_unit #(
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_DATA,
  input  logic [31:0] MEM_Q
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_write, r_unsigned, r_err;
  logic [1:0]  r_size, r_lo;
  logic [31:0] r_wdata, r_old, r_rdata, r_mem_addr;
  logic        w_accept, w_req_err, w_subword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merged;

  assign w_accept  = REQ_VALID && (r_state == S_IDLE);
  assign w_req_err = (REQ_SIZE == 2'b11)
                  || (REQ_SIZE == 2'b01 && REQ_ADDR[0])
                  || (REQ_SIZE == 2'b10 && REQ_ADDR[1:0] != 2'b00)
                  || ({2'b00, REQ_ADDR[31:2]} >= 32'(DEPTH));
  assign w_subword = r_write && (r_size != 2'b10);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_req_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = w_subword ? S_WRITE : S_RESP;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   if (RESP_READY) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Little-endian lane pick from the addressed word, then extension.
  always_comb begin
    w_byte = MEM_Q[{r_lo, 3'b000} +: 8];
    w_half = r_lo[1] ? MEM_Q[31:16] : MEM_Q[15:0];
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = MEM_Q;
    endcase
  end

  always_comb begin
    w_merged = r_old;
    if (r_size == 2'b00) w_merged[{r_lo, 3'b000} +: 8]        = r_wdata[7:0];
    else                 w_merged[{r_lo[1], 4'b0000} +: 16]   = r_wdata[15:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_lo       <= 2'b00;
      r_wdata    <= 32'h0;
      r_old      <= 32'h0;
      r_rdata    <= 32'h0;
      r_mem_addr <= 32'h0;
    end else if (w_accept) begin
      r_write    <= REQ_WRITE;
      r_unsigned <= REQ_UNSIGNED;
      r_err      <= w_req_err;
      r_size     <= REQ_SIZE;
      r_lo       <= REQ_ADDR[1:0];
      r_wdata    <= REQ_WDATA;
      r_rdata    <= 32'h0;
      r_mem_addr <= {2'b00, REQ_ADDR[31:2]};
    end else if (r_state == S_ACCESS) begin
      if (!r_write) r_rdata <= w_load;
      if (w_subword) r_old <= MEM_Q;
    end
  end

  // Outputs decode straight from state so MEM_WE falls with RST, not on the next edge.
  always_comb begin
    REQ_READY   = (r_state == S_IDLE);
    RESP_VALID  = (r_state == S_RESP);
    RESP_RDATA  = r_rdata;
    RESP_ERR    = r_err;
    MEM_ADDRESS = r_mem_addr;
    MEM_WE      = 1'b0;
    MEM_DATA    = 32'h0;
    if (r_state == S_ACCESS && r_write && !w_subword) begin
      MEM_WE   = 1'b1;
      MEM_DATA = r_wdata;
    end else if (r_state == S_WRITE) begin
      MEM_WE   = 1'b1;
      MEM_DATA = w_merged;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WRITE, REQ_UNSIGNED;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RESP_VALID, RESP_READY, RESP_ERR;
  logic [31:0] RESP_RDATA;
  logic        MEM_WE;
  logic [31:0] MEM_ADDRESS, MEM_DATA, MEM_Q;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR), .MEM_WE(MEM_WE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA(MEM_DATA), .MEM_Q(MEM_Q)
  );

  always #5 CLK = ~CLK;

  // Word-addressed data memory seen by the DUT.
  logic [31:0] mem [0:DEPTH-1];
  int we_cnt = 0;
  assign MEM_Q = (MEM_ADDRESS < 32'(DEPTH)) ? mem[MEM_ADDRESS[9:0]] : 32'h0;
  always @(posedge CLK) begin
    if (MEM_WE) begin
      we_cnt <= we_cnt + 1;
      if (MEM_ADDRESS < 32'(DEPTH)) mem[MEM_ADDRESS[9:0]] <= MEM_DATA;
    end
  end

  // Reference model: flat little-endian byte array.
  logic [7:0] ref_mem [0:4*DEPTH-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int wes);
    int n;
    logic [63:0] v;
    er  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
       || ((a >> 2) >= 32'(DEPTH));
    rd  = 32'h0;
    wes = 0;
    lat = 1;
    if (!er) begin
      n = 1 << sz;
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        wes = 1;
        lat = (n == 4) ? 2 : 3;
      end else begin
        v = 64'h0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + 32'(i)]) << (8*i));
        if (!u && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        rd  = v[31:0];
        lat = 2;
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int wes);
    int we0;
    int waitc;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_SIZE = sz; REQ_UNSIGNED = u;
    REQ_ADDR = a; REQ_WDATA = wd;
    waitc = 0;
    while (!REQ_READY && waitc < 20) begin @(negedge CLK); waitc++; end
    we0 = we_cnt;
    @(posedge CLK); #1;
    // Scramble inputs after acceptance: the captured request must not change.
    REQ_VALID = 1'b0; REQ_ADDR = $urandom; REQ_WDATA = $urandom;
    REQ_WRITE = 1'($urandom_range(1, 0)); REQ_SIZE = 2'($urandom_range(3, 0));
    REQ_UNSIGNED = 1'($urandom_range(1, 0));
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!RESP_VALID && lat < 20);
    rd = RESP_RDATA;
    er = RESP_ERR;
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    wes = we_cnt - we0;
  endtask

  task automatic run_check(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, elat, wes, ewes;
    model(w, sz, u, a, wd, erd, eer, elat, ewes);
    do_req(w, sz, u, a, wd, rd, er, lat, wes);
    chk({tag, " rdata"}, rd, erd);
    chk({tag, " err"}, 32'(er), 32'(eer));
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " we_cycles"}, 32'(wes), 32'(ewes));
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [31:0] rd, mrd, word;
    logic er, mer;
    int lat, wes, mlat, mwes, waitc;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h0;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h0; REQ_WDATA = 32'h0; RESP_READY = 1'b0;
    repeat (3) @(negedge CLK);

    chk("reset req_ready", 32'(REQ_READY), 32'd1);
    chk("reset resp_valid", 32'(RESP_VALID), 32'd0);
    chk("reset resp_err", 32'(RESP_ERR), 32'd0);
    chk("reset resp_rdata", RESP_RDATA, 32'h0);
    chk("reset mem_we", 32'(MEM_WE), 32'd0);
    chk("reset mem_address", MEM_ADDRESS, 32'h0);
    chk("reset mem_data", MEM_DATA, 32'h0);
    RST = 1'b0;

    //            w     sz     u     addr          wdata         rdata         err   lat
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,       32'h7F,       32'h0,        1'b0, 3};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h7FADBEEF, 1'b0, 2};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h12,       32'h0,        32'hFFFFFFAD, 1'b0, 2};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h12,       32'h0,        32'h000000AD, 1'b0, 2};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h11,       32'h0,        32'h0,        1'b1, 1};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h12,       32'h0,        32'h0,        1'b1, 1};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1, 1};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1, 1};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h1000,     32'h55555555, 32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h16,       32'h1234,     32'h0,        1'b0, 3};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h16,       32'h0,        32'h00001234, 1'b0, 2};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h14,       32'h0,        32'h12340000, 1'b0, 2};
    tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h14,       32'hFFFFFF80, 32'h0,        1'b0, 3};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h14,       32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h16,       32'h8001,     32'h0,        1'b0, 3};
    tbl[17] = '{1'b0, 2'd1, 1'b0, 32'h16,       32'h0,        32'hFFFF8001, 1'b0, 2};

    for (int i = 0; i < 18; i++) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, mrd, mer, mlat, mwes);
      do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rd, er, lat, wes);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].er));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d we_cycles", i), 32'(wes), (tbl[i].w && !tbl[i].er) ? 32'd1 : 32'd0);
    end
    chk("mem word 4 after byte store", mem[4], 32'h7FADBEEF);
    chk("mem word 5 after half stores", mem[5], 32'h80010080);
    run_check("last word load", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);

    // Response backpressure: held for 5 cycles, everything stays put.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_SIZE = 2'd2; REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h10;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_ADDR = 32'h20;
    waitc = 0;
    do begin @(negedge CLK); waitc++; end while (!RESP_VALID && waitc < 20);
    for (int k = 0; k < 5; k++) begin
      chk("stall resp_valid", 32'(RESP_VALID), 32'd1);
      chk("stall resp_rdata", RESP_RDATA, 32'h7FADBEEF);
      chk("stall req_ready", 32'(REQ_READY), 32'd0);
      chk("stall mem_address", MEM_ADDRESS, 32'd4);
      @(negedge CLK);
    end
    RESP_READY = 1'b1;
    @(posedge CLK); #1;
    RESP_READY = 1'b0;
    chk("release req_ready", 32'(REQ_READY), 32'd1);
    chk("release resp_valid", 32'(RESP_VALID), 32'd0);
    run_check("after release", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

    // Reset during the write cycle of a sub-word store aborts it.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_SIZE = 2'd0; REQ_ADDR = 32'h10; REQ_WDATA = 32'hAA;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("rmw read cycle mem_we", 32'(MEM_WE), 32'd0);
    @(negedge CLK);
    chk("rmw write cycle mem_we", 32'(MEM_WE), 32'd1);
    chk("rmw write cycle mem_data", MEM_DATA, 32'h7FADBEAA);
    RST = 1'b1;
    #1;
    chk("abort mem_we", 32'(MEM_WE), 32'd0);
    chk("abort req_ready", 32'(REQ_READY), 32'd1);
    chk("abort resp_valid", 32'(RESP_VALID), 32'd0);
    chk("abort resp_err", 32'(RESP_ERR), 32'd0);
    chk("abort resp_rdata", RESP_RDATA, 32'h0);
    chk("abort mem_address", MEM_ADDRESS, 32'h0);
    chk("abort mem_data", MEM_DATA, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("abort mem word unchanged", mem[4], 32'h7FADBEEF);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      if ($urandom_range(15, 0) == 0) a = $urandom;
      else if ($urandom_range(15, 0) == 0) a = 32'hFF0 + 32'($urandom_range(31, 0));
      else a = 32'($urandom_range(255, 0));
      run_check($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                1'($urandom_range(1, 0)), a, $urandom);
    end
    for (int i = 0; i < 64; i++) begin
      word = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      chk($sformatf("final mem word %0d", i), mem[i], word);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
